// File: rtl/rb_bank_arbiter.sv
// rb_bank_arbiter: round-robin, burst-bounded, lockable arbiter sharing one single-port register bank between two requesters
module rb_bank_arbiter #(
  parameter int MAX_BURST = 18,
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          rw0,
  input  logic          rw1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          RB_RW,
  output logic [AW-1:0] RB_A,
  output logic [DW-1:0] RB_D,
  input  logic [DW-1:0] RB_Q
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic rb_rw_q, rb_rw_d, v1_q, v1_d, v2_q, v2_d, id1_q, id1_d, id2_q, id2_d;
  logic rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [AW-1:0] rb_a_q, rb_a_d;
  logic [DW-1:0] rb_d_q, rb_d_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic own1, req_s, lock_s, rw_s, oreq, xfer, pick1;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] wdata_s;
  always_comb begin
    own1 = state_q == OWN1;
    req_s = own1 ? req1 : req0;
    lock_s = own1 ? lock1 : lock0;
    rw_s = own1 ? rw1 : rw0;
    addr_s = own1 ? addr1 : addr0;
    wdata_s = own1 ? wdata1 : wdata0;
    oreq = own1 ? req0 : req1;
    xfer = (state_q != IDLE) && req_s;
    pick1 = req1 && (!req0 || !last_q);
    cnt_inc = xfer && cnt_q != MAXC ? cnt_q + 1'b1 : cnt_q;
    state_d = state_q;
    last_d = last_q;
    cnt_d = cnt_inc;
    if (state_q == IDLE) begin
      if (req0 || req1) begin
        state_d = pick1 ? OWN1 : OWN0;
        last_d = pick1;
        cnt_d = '0;
      end
    end else if (!lock_s && (!req_s || (xfer && cnt_inc == MAXC && oreq))) begin
      state_d = IDLE;
    end
    gnt0_d = state_d == OWN0;
    gnt1_d = state_d == OWN1;
    rb_rw_d = xfer ? rw_s : 1'b1;
    rb_a_d = xfer ? addr_s : rb_a_q;
    rb_d_d = xfer ? wdata_s : rb_d_q;
    v1_d = xfer && rw_s;
    id1_d = own1;
    v2_d = v1_q;
    id2_d = id1_q;
    rvalid0_d = v2_q && !id2_q;
    rvalid1_d = v2_q && id2_q;
    rdata0_d = rvalid0_d ? RB_Q : rdata0_q;
    rdata1_d = rvalid1_d ? RB_Q : rdata1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      cnt_q <= '0;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      rb_rw_q <= 1'b1;
      rb_a_q <= '0;
      rb_d_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      id1_q <= 1'b0;
      id2_q <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      gnt0_q <= gnt0_d;
      gnt1_q <= gnt1_d;
      rb_rw_q <= rb_rw_d;
      rb_a_q <= rb_a_d;
      rb_d_q <= rb_d_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      id1_q <= id1_d;
      id2_q <= id2_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign RB_RW = rb_rw_q;
  assign RB_A = rb_a_q;
  assign RB_D = rb_d_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule

// File: tb/tb_rb_bank_arbiter.sv
// tb_rb_bank_arbiter: directed self-checking bench with a behavioural 32x8 bank model
module tb_rb_bank_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, rw0 = 1, rw1 = 1;
  logic [4:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, rb_rw;
  logic [7:0] rdata0, rdata1, rb_d, rb_q;
  logic [4:0] rb_a;
  logic [7:0] mem [32];
  logic poke_en = 0;
  logic [4:0] poke_a = 0;
  logic [7:0] poke_d = 0;
  int n_cmp = 0, n_bad = 0;
  rb_bank_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .rw0(rw0), .rw1(rw1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .RB_RW(rb_rw), .RB_A(rb_a), .RB_D(rb_d), .RB_Q(rb_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (poke_en) mem[poke_a] <= poke_d;
    else if (!rb_rw) mem[rb_a] <= rb_d;
    else rb_q <= mem[rb_a];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, {gnt0, gnt1}, 0);
    chk({tag, "_rvalid"}, {rvalid0, rvalid1}, 0);
    chk({tag, "_rdata"}, {rdata0, rdata1}, 0);
    chk({tag, "_rb_rw"}, rb_rw, 1);
    chk({tag, "_rb_a"}, rb_a, 0);
    chk({tag, "_rb_d"}, rb_d, 0);
  endtask
  initial begin
    logic [7:0] e;
    poke_en = 1;
    for (int a = 0; a < 32; a++) begin
      poke_a = 5'(a);
      poke_d = 8'(a + 'h40);
      tick();
    end
    poke_en = 0;
    chk_reset_vals("reset");
    rst = 0;
    req1 = 1; rw1 = 1; addr1 = 17;
    tick();
    chk("t1_gnt1", gnt1, 1);
    for (int k = 0; k <= 20; k++) begin
      req1 = k < 18;
      addr1 = k < 18 ? 5'(17 - k) : 5'd0;
      tick();
      chk("t1_rvalid1", rvalid1, k >= 2 && k < 20);
      chk("t1_rvalid0", rvalid0, 0);
      e = 8'h51 - 8'(k - 2);
      if (k >= 2 && k < 20) chk("t1_rdata1", rdata1, e);
    end
    poke_en = 1; poke_a = 9; poke_d = 8'h77;
    tick();
    poke_en = 0;
    req0 = 1; rw0 = 0; addr0 = 3; wdata0 = 8'hA5;
    tick();
    chk("t2_gnt0", gnt0, 1);
    tick();
    chk("t2_wr_cmd", {rb_rw, rb_a, rb_d}, {1'b0, 5'd3, 8'hA5});
    rw0 = 1;
    tick();
    chk("t2_rd_cmd", {rb_rw, rb_a}, {1'b1, 5'd3});
    req0 = 0;
    tick();
    chk("t2_rw_idle", rb_rw, 1);
    chk("t2_rvalid0_early", rvalid0, 0);
    tick();
    chk("t2_rvalid0", rvalid0, 1);
    chk("t2_rdata0", rdata0, 8'hA5);
    chk("t2_rvalid1", rvalid1, 0);
    tick();
    chk("t2_rvalid0_once", rvalid0, 0);
    rst = 1; req0 = 1; req1 = 1; rw0 = 1; rw1 = 1; addr0 = 0; addr1 = 1;
    tick();
    rst = 0;
    tick();
    chk("t3_first_gnt", {gnt0, gnt1}, 2'b10);
    for (int j = 2; j <= 40; j++) begin
      addr0 = j == 19 ? 5'd9 : 5'd0;
      tick();
      chk("t3_gnt0", gnt0, j <= 18 || j >= 39);
      chk("t3_gnt1", gnt1, j >= 20 && j <= 37);
      chk("t3_rvalid0", rvalid0, j >= 4 && j <= 21);
      chk("t3_rvalid1", rvalid1, j >= 23 && j <= 40);
      if (j == 21) chk("t5_rdata0_handover", rdata0, 8'h77);
    end
    rst = 1; req0 = 1; lock0 = 1; req1 = 1; rw0 = 1;
    tick();
    rst = 0;
    tick();
    chk("t4_gnt0", gnt0, 1);
    req0 = 0; rw0 = 0; addr0 = 7; wdata0 = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_lock_gnt", {gnt0, gnt1}, 2'b10);
      chk("t4_no_write", rb_rw, 1);
    end
    lock0 = 0;
    tick();
    chk("t4_idle", {gnt0, gnt1}, 2'b00);
    tick();
    chk("t4_gnt1", {gnt0, gnt1}, 2'b01);
    rw1 = 1; addr1 = 5;
    tick();
    chk("t6_read_cmd", {rb_rw, rb_a}, {1'b1, 5'd5});
    tick();
    rst = 1;
    #1;
    chk_reset_vals("t6_async");
    tick();
    rst = 0;
    tick();
    chk("t6_gnt1", {gnt0, gnt1}, 2'b01);
    chk("t6_flush_a", rvalid1, 0);
    tick();
    chk("t6_flush_b", rvalid1, 0);
    tick();
    chk("t6_flush_c", {rvalid0, rvalid1}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
